// File: rtl/warp_fetcher.sv
// Per-warp instruction fetch stage: one valid/ready program-memory read per WARP_FETCH,
// with a saturating stall counter. Define FETCHER_LAST_PC_BUF_EN for a last-PC instruction buffer.

package warp_fetcher_pkg;

    typedef enum logic [2:0] {
        WARP_IDLE    = 3'd0,
        WARP_FETCH   = 3'd1,
        WARP_DECODE  = 3'd2,
        WARP_REQUEST = 3'd3,
        WARP_WAIT    = 3'd4,
        WARP_EXECUTE = 3'd5,
        WARP_UPDATE  = 3'd6,
        WARP_DONE    = 3'd7
    } warp_state_t;

    typedef enum logic [1:0] {
        FETCHER_IDLE     = 2'd0,
        FETCHER_FETCHING = 2'd1,
        FETCHER_FETCHED  = 2'd2
    } fetcher_state_t;

    typedef logic [31:0] instruction_t;

endpackage

module warp_fetcher
    import warp_fetcher_pkg::*;
#(
    parameter int unsigned PROGRAM_ADDR_BITS = 8,
    parameter int unsigned INSTR_WIDTH       = 32,
    parameter int unsigned STALL_CNT_BITS    = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  warp_state_t                  warp_state,
    input  logic [PROGRAM_ADDR_BITS-1:0] pc,
    output logic                         mem_read_valid,
    output logic [PROGRAM_ADDR_BITS-1:0] mem_read_address,
    input  logic                         mem_read_ready,
    input  logic [INSTR_WIDTH-1:0]       mem_read_data,
    output fetcher_state_t               fetcher_state,
    output instruction_t                 instruction,
    output logic [STALL_CNT_BITS-1:0]    stall_cycles
);

    fetcher_state_t                 state_q, state_d;
    logic                           valid_q, valid_d;
    logic [PROGRAM_ADDR_BITS-1:0]   addr_q, addr_d;
    instruction_t                   instr_q, instr_d;
    logic [STALL_CNT_BITS-1:0]      stall_q, stall_d;
    logic                           buf_hit;

`ifdef FETCHER_LAST_PC_BUF_EN
    logic                           buf_valid_q;
    logic [PROGRAM_ADDR_BITS-1:0]   buf_pc_q;
    instruction_t                   buf_instr_q;
    logic                           mem_done;

    assign mem_done = (state_q == FETCHER_FETCHING) && mem_read_ready;
    assign buf_hit  = buf_valid_q && (buf_pc_q == pc);

    // Captures the launch address, not the live pc, so the entry matches what memory returned.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            buf_valid_q <= 1'b0;
            buf_pc_q    <= '0;
            buf_instr_q <= '0;
        end else if (mem_done) begin
            buf_valid_q <= 1'b1;
            buf_pc_q    <= addr_q;
            buf_instr_q <= mem_read_data;
        end
    end
`else
    assign buf_hit = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        addr_d  = addr_q;
        instr_d = instr_q;
        stall_d = stall_q;
        unique case (state_q)
            FETCHER_IDLE: begin
                if (warp_state == WARP_FETCH) begin
                    if (buf_hit) begin
`ifdef FETCHER_LAST_PC_BUF_EN
                        instr_d = buf_instr_q;
`endif
                        state_d = FETCHER_FETCHED;
                    end else begin
                        state_d = FETCHER_FETCHING;
                        valid_d = 1'b1;
                        addr_d  = pc;
                    end
                end
            end
            FETCHER_FETCHING: begin
                if (mem_read_ready) begin
                    instr_d = mem_read_data;
                    valid_d = 1'b0;
                    state_d = FETCHER_FETCHED;
                end else if (stall_q != '1) begin
                    stall_d = stall_q + 1'b1;
                end
            end
            FETCHER_FETCHED: begin
                if (warp_state == WARP_DECODE) begin
                    state_d = FETCHER_IDLE;
                end
            end
            default: begin
                state_d = FETCHER_IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= FETCHER_IDLE;
            valid_q <= 1'b0;
            addr_q  <= '0;
            instr_q <= '0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            addr_q  <= addr_d;
            instr_q <= instr_d;
            stall_q <= stall_d;
        end
    end

    assign fetcher_state    = state_q;
    assign mem_read_valid   = valid_q;
    assign mem_read_address = addr_q;
    assign instruction      = instr_q;
    assign stall_cycles     = stall_q;

endmodule

// File: tb/tb_warp_fetcher.sv
// Randomized bench for warp_fetcher with a transaction-level reference model.
// Expectations for the last-PC buffer follow FETCHER_LAST_PC_BUF_EN.

module tb_warp_fetcher;
    import warp_fetcher_pkg::*;

    localparam int SAT = 15;

    logic           clk;
    logic           reset;
    warp_state_t    warp_state;
    logic [7:0]     pc;
    logic           mem_read_valid;
    logic [7:0]     mem_read_address;
    logic           mem_read_ready;
    logic [31:0]    mem_read_data;
    fetcher_state_t fetcher_state;
    instruction_t   instruction;
    logic [3:0]     stall_cycles;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: expected instruction, stall total, last-fetch buffer contents.
    logic [31:0] m_instr;
    int          m_stall;
    bit          m_buf_valid;
    logic [7:0]  m_buf_pc;
    logic [31:0] m_buf_instr;

    warp_fetcher #(
        .PROGRAM_ADDR_BITS(8),
        .INSTR_WIDTH      (32),
        .STALL_CNT_BITS   (4)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .warp_state      (warp_state),
        .pc              (pc),
        .mem_read_valid  (mem_read_valid),
        .mem_read_address(mem_read_address),
        .mem_read_ready  (mem_read_ready),
        .mem_read_data   (mem_read_data),
        .fetcher_state   (fetcher_state),
        .instruction     (instruction),
        .stall_cycles    (stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, required finish before 200000");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic warp_state_t rand_non_decode();
        warp_state_t w;
        w = warp_state_t'($urandom_range(0, 7));
        if (w == WARP_DECODE) w = WARP_WAIT;
        return w;
    endfunction

    task automatic model_reset();
        m_instr     = 32'h0;
        m_stall     = 0;
        m_buf_valid = 1'b0;
        m_buf_pc    = 8'h0;
        m_buf_instr = 32'h0;
    endtask

    // Issue one fetch from IDLE; memory answers after `delay` stalled cycles.
    task automatic do_fetch(input logic [7:0] p, input logic [31:0] d, input int delay,
                            input bit wiggle);
        bit hit;
        hit = 1'b0;
`ifdef FETCHER_LAST_PC_BUF_EN
        hit = m_buf_valid && (m_buf_pc == p);
`endif
        warp_state     = WARP_FETCH;
        pc             = p;
        mem_read_ready = 1'b0;
        step();
        if (hit) begin
            m_instr = m_buf_instr;
            chk("hit_state", 32'(fetcher_state), 32'(FETCHER_FETCHED));
            chk("hit_valid", 32'(mem_read_valid), 32'd0);
            chk("hit_instr", instruction, m_instr);
            chk("hit_stall", 32'(stall_cycles), 32'(m_stall));
        end else begin
            chk("launch_state", 32'(fetcher_state), 32'(FETCHER_FETCHING));
            chk("launch_valid", 32'(mem_read_valid), 32'd1);
            chk("launch_addr", 32'(mem_read_address), 32'(p));
            for (int k = 0; k < delay; k++) begin
                warp_state    = warp_state_t'($urandom_range(0, 7));
                mem_read_data = $urandom;
                if (wiggle) pc = 8'($urandom);
                step();
                m_stall = (m_stall + 1 > SAT) ? SAT : m_stall + 1;
                chk("stall_state", 32'(fetcher_state), 32'(FETCHER_FETCHING));
                chk("stall_valid", 32'(mem_read_valid), 32'd1);
                chk("stall_addr", 32'(mem_read_address), 32'(p));
                chk("stall_count", 32'(stall_cycles), 32'(m_stall));
            end
            mem_read_ready = 1'b1;
            mem_read_data  = d;
            step();
            mem_read_ready = 1'b0;
            mem_read_data  = $urandom;
            m_instr     = d;
            m_buf_valid = 1'b1;
            m_buf_pc    = p;
            m_buf_instr = d;
            chk("done_state", 32'(fetcher_state), 32'(FETCHER_FETCHED));
            chk("done_valid", 32'(mem_read_valid), 32'd0);
            chk("done_instr", instruction, m_instr);
            chk("done_stall", 32'(stall_cycles), 32'(m_stall));
        end
    endtask

    // Linger in FETCHED, hand off through DECODE, then poke a stray ready in IDLE.
    task automatic handoff(input int hold);
        for (int k = 0; k < hold; k++) begin
            warp_state     = rand_non_decode();
            mem_read_ready = 1'($urandom);
            mem_read_data  = $urandom;
            step();
            chk("hold_state", 32'(fetcher_state), 32'(FETCHER_FETCHED));
            chk("hold_instr", instruction, m_instr);
        end
        warp_state     = WARP_DECODE;
        mem_read_ready = 1'b0;
        step();
        chk("decode_state", 32'(fetcher_state), 32'(FETCHER_IDLE));
        chk("decode_instr", instruction, m_instr);
        warp_state     = WARP_IDLE;
        mem_read_ready = 1'b1;
        mem_read_data  = $urandom;
        step();
        mem_read_ready = 1'b0;
        chk("stray_state", 32'(fetcher_state), 32'(FETCHER_IDLE));
        chk("stray_instr", instruction, m_instr);
        chk("stray_valid", 32'(mem_read_valid), 32'd0);
        chk("stray_stall", 32'(stall_cycles), 32'(m_stall));
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_state"}, 32'(fetcher_state), 32'(FETCHER_IDLE));
        chk({tag, "_valid"}, 32'(mem_read_valid), 32'd0);
        chk({tag, "_addr"}, 32'(mem_read_address), 32'd0);
        chk({tag, "_instr"}, instruction, 32'd0);
        chk({tag, "_stall"}, 32'(stall_cycles), 32'd0);
    endtask

    // Pulse reset between clock edges; outputs must clear with no edge.
    task automatic async_reset(input string tag);
        #1 reset = 1'b0;
        #1;
        model_reset();
        check_reset_outputs(tag);
        warp_state = WARP_IDLE;
        #1 reset = 1'b1;
    endtask

    initial begin
        reset          = 1'b0;
        warp_state     = WARP_IDLE;
        pc             = 8'h00;
        mem_read_ready = 1'b0;
        mem_read_data  = 32'h0;
        model_reset();
        #3;
        check_reset_outputs("por");
        reset = 1'b1;
        step();

        // Basic fetch, ready on first FETCHING edge.
        do_fetch(8'h05, 32'hA000_1234, 0, 1'b0);
        handoff(1);

        // Mid-simulation async reset clears everything, including the buffer.
        async_reset("async_rst");
        step();

        // Stall of 3 with pc moving during the stall.
        do_fetch(8'h05, 32'h1357_9BDF, 3, 1'b1);
        handoff(2);

        // Same pc twice: buffer hit when enabled, second memory read otherwise.
        do_fetch(8'h10, 32'hCAFE_0010, 1, 1'b0);
        handoff(0);
        do_fetch(8'h10, 32'hCAFE_0010, 0, 1'b0);
        handoff(0);

        // Saturation of the 4-bit counter.
        do_fetch(8'h22, 32'h8000_0001, 20, 1'b0);
        handoff(0);

        async_reset("pre_rand");
        step();

        for (int i = 0; i < 40; i++) begin
            do_fetch(8'(8'h40 + $urandom_range(0, 3)), $urandom, $urandom_range(0, 6),
                     1'($urandom));
            handoff($urandom_range(0, 2));
        end

        // Reset while FETCHING drops valid; a later ready in IDLE is ignored.
        warp_state = WARP_FETCH;
        pc         = 8'h33;
        step();
        chk("midrst_launch", 32'(mem_read_valid), 32'd1);
        warp_state = WARP_IDLE;
        #1 reset = 1'b0;
        #1;
        model_reset();
        chk("midrst_valid", 32'(mem_read_valid), 32'd0);
        chk("midrst_state", 32'(fetcher_state), 32'(FETCHER_IDLE));
        mem_read_ready = 1'b1;
        mem_read_data  = 32'hDEAD_BEEF;
        #1 reset = 1'b1;
        step();
        mem_read_ready = 1'b0;
        check_reset_outputs("midrst_after");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
